// File: rtl/vga_stream_out_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared video definitions:
//   - default 640x480@60 timing constants
//   - RGB565 field positions inside a 16-bit pixel word
//   - expand5to6(): widens a 5-bit channel to 6 bits by replicating its MSB
//   - scan_total(): total line/frame length from active + porches + sync
// -----------------------------------------------------------------------------
package video_pkg;

   // Default 480p timing
   localparam int DEF_CORDW    = 10;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // RGB565 layout
   localparam int PIX_W     = 16;
   localparam int RGB_R_MSB = 15;
   localparam int RGB_R_LSB = 11;
   localparam int RGB_G_MSB = 10;
   localparam int RGB_G_LSB = 5;
   localparam int RGB_B_MSB = 4;
   localparam int RGB_B_LSB = 0;

   // MSB replication maps 0 -> 0 and 31 -> 63, so full scale stays full scale.
   function automatic logic [5:0] expand5to6(input logic [4:0] v);
      return {v, v[4]};
   endfunction

   function automatic int scan_total(input int active, input int fp,
                                     input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_stream_out_if.sv
// -----------------------------------------------------------------------------
// vga_stream_out_if
// Read port of a standard (non-FWFT) video FIFO.
//   fifo_dout  : RGB565 pixel, valid one cycle after fifo_rd_en
//   fifo_empty : FIFO has no data
//   fifo_rd_en : read strobe
// Modports: master = reader (scan-out), slave = FIFO.
// -----------------------------------------------------------------------------
interface vga_stream_out_if;
   import video_pkg::*;

   logic [PIX_W-1:0] fifo_dout;
   logic             fifo_empty;
   logic             fifo_rd_en;

   modport master (input fifo_dout, input fifo_empty, output fifo_rd_en);
   modport slave  (output fifo_dout, output fifo_empty, input fifo_rd_en);
endinterface

// File: rtl/display_timings_param.sv
// -----------------------------------------------------------------------------
// display_timings_param
// Counter-based video timing generator for any resolution.
// Ports:
//   clk_pix     in   pixel clock
//   rst         in   synchronous active-low reset
//   sx, sy      out  current position (registered counters)
//   de          out  inside active video
//   hs_act      out  inside hsync pulse (polarity applied by the user)
//   vs_act      out  inside vsync pulse (polarity applied by the user)
//   frame_start out  high at sx=0, sy=0
// All decoded outputs are combinational from the counters.
// -----------------------------------------------------------------------------
module display_timings_param
   import video_pkg::*;
#(
   parameter int CORDW    = DEF_CORDW,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic             clk_pix,
   input  logic             rst,
   output logic [CORDW-1:0] sx,
   output logic [CORDW-1:0] sy,
   output logic             de,
   output logic             hs_act,
   output logic             vs_act,
   output logic             frame_start
);

   localparam int H_TOTAL = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   // One spare bit keeps sums such as ACTIVE+FP+SYNC from wrapping.
   localparam int CW1 = CORDW + 1;
   localparam logic [CW1-1:0] H_LAST   = CW1'(H_TOTAL - 1);
   localparam logic [CW1-1:0] V_LAST   = CW1'(V_TOTAL - 1);
   localparam logic [CW1-1:0] H_ACT    = CW1'(H_ACTIVE);
   localparam logic [CW1-1:0] V_ACT    = CW1'(V_ACTIVE);
   localparam logic [CW1-1:0] HS_START = CW1'(H_ACTIVE + H_FP);
   localparam logic [CW1-1:0] HS_END   = CW1'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW1-1:0] VS_START = CW1'(V_ACTIVE + V_FP);
   localparam logic [CW1-1:0] VS_END   = CW1'(V_ACTIVE + V_FP + V_SYNC);

   logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
   logic [CW1-1:0]   sx_w, sy_w;

   assign sx_w = {1'b0, sx_q};
   assign sy_w = {1'b0, sy_q};

   always_comb begin
      sx_d = sx_q + CORDW'(1);
      sy_d = sy_q;
      if (sx_w == H_LAST) begin
         sx_d = '0;
         sy_d = (sy_w == V_LAST) ? '0 : sy_q + CORDW'(1);
      end
   end

   always_ff @(posedge clk_pix) begin
      if (!rst) begin
         sx_q <= '0;
         sy_q <= '0;
      end else begin
         sx_q <= sx_d;
         sy_q <= sy_d;
      end
   end

   assign sx          = sx_q;
   assign sy          = sy_q;
   assign de          = (sx_w < H_ACT) && (sy_w < V_ACT);
   assign hs_act      = (sx_w >= HS_START) && (sx_w < HS_END);
   assign vs_act      = (sy_w >= VS_START) && (sy_w < VS_END);
   assign frame_start = (sx_q == '0) && (sy_q == '0);

endmodule

// File: rtl/vga_stream_out.sv
// -----------------------------------------------------------------------------
// vga_stream_out
// VGA scan-out stage: reads RGB565 pixels from a standard-read video FIFO
// during active video, expands them to 6 bits per channel and drives the pins.
// Ports:
//   clk_pix, rst      pixel clock, synchronous active-low reset
//   fifo              FIFO read port (vga_stream_out_if.master)
//   clr_underflow     clears the sticky underflow flag
//   sx, sy            stage-0 position; vga_* outputs lag these by 2 cycles
//   frame_start       high at sx=0, sy=0
//   underflow         sticky: set by an active-video cycle with an empty FIFO
//   vga_hsync/vsync   registered syncs, aligned with colour
//   vga_r/g/b         6-bit colour, black outside active video
// Optional build macro VGA_TEST_PATTERN_EN: underrun pixels show colour bars
// instead of black.
// -----------------------------------------------------------------------------
module vga_stream_out
   import video_pkg::*;
#(
   parameter int CORDW    = DEF_CORDW,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0
) (
   input  logic                clk_pix,
   input  logic                rst,
   vga_stream_out_if.master    fifo,
   input  logic                clr_underflow,
   output logic [CORDW-1:0]    sx,
   output logic [CORDW-1:0]    sy,
   output logic                frame_start,
   output logic                underflow,
   output logic                vga_hsync,
   output logic                vga_vsync,
   output logic [5:0]          vga_r,
   output logic [5:0]          vga_g,
   output logic [5:0]          vga_b
);

   logic de0, hs0, vs0, rd_en0;

   display_timings_param #(
      .CORDW(CORDW),
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timings (
      .clk_pix(clk_pix),
      .rst(rst),
      .sx(sx),
      .sy(sy),
      .de(de0),
      .hs_act(hs0),
      .vs_act(vs0),
      .frame_start(frame_start)
   );

   // Never read outside active video so blanking leaves the FIFO untouched.
   assign rd_en0          = de0 && !fifo.fifo_empty;
   assign fifo.fifo_rd_en = rd_en0;

   // Stage 1: matches the FIFO's one-cycle read latency.
   logic de1_q, hs1_q, vs1_q, pix_ok1_q;

   always_ff @(posedge clk_pix) begin
      if (!rst) begin
         de1_q     <= 1'b0;
         hs1_q     <= 1'b0;
         vs1_q     <= 1'b0;
         pix_ok1_q <= 1'b0;
      end else begin
         de1_q     <= de0;
         hs1_q     <= hs0;
         vs1_q     <= vs0;
         pix_ok1_q <= rd_en0;
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   // Bar index taken from sx one cycle late, i.e. the pixel now in stage 1.
   logic [2:0] bar1_q;

   always_ff @(posedge clk_pix) begin
      if (!rst) bar1_q <= '0;
      else      bar1_q <= sx[CORDW-4 -: 3];
   end
`endif

   // Stage 2: output registers.
   logic [5:0] r_q, g_q, b_q, r_d, g_d, b_d;
   logic       hsync_q, vsync_q;

   always_comb begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (de1_q) begin
         if (pix_ok1_q) begin
            r_d = expand5to6(fifo.fifo_dout[RGB_R_MSB:RGB_R_LSB]);
            g_d = fifo.fifo_dout[RGB_G_MSB:RGB_G_LSB];
            b_d = expand5to6(fifo.fifo_dout[RGB_B_MSB:RGB_B_LSB]);
         end else begin
`ifdef VGA_TEST_PATTERN_EN
            r_d = {6{bar1_q[2]}};
            g_d = {6{bar1_q[1]}};
            b_d = {6{bar1_q[0]}};
`endif
         end
      end
   end

   always_ff @(posedge clk_pix) begin
      if (!rst) begin
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         hsync_q <= ~H_POL;
         vsync_q <= ~V_POL;
      end else begin
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         hsync_q <= hs1_q ? H_POL : ~H_POL;
         vsync_q <= vs1_q ? V_POL : ~V_POL;
      end
   end

   // Sticky underflow; a new event outranks a simultaneous clear.
   logic underflow_q, underflow_d;

   always_comb begin
      underflow_d = underflow_q;
      if (clr_underflow)            underflow_d = 1'b0;
      if (de0 && fifo.fifo_empty)   underflow_d = 1'b1;
   end

   always_ff @(posedge clk_pix) begin
      if (!rst) underflow_q <= 1'b0;
      else      underflow_q <= underflow_d;
   end

   assign underflow = underflow_q;
   assign vga_hsync = hsync_q;
   assign vga_vsync = vsync_q;
   assign vga_r     = r_q;
   assign vga_g     = g_q;
   assign vga_b     = b_q;

endmodule

// File: tb/tb_vga_stream_out.sv
// -----------------------------------------------------------------------------
// tb_vga_stream_out
// Directed bench for vga_stream_out in a small 16x8 timing (8x4 active).
// Sample point is 1 time unit after each rising edge; sample t has sx=t%16,
// sy=(t/16)%8 counted from reset release.
// -----------------------------------------------------------------------------
module tb_vga_stream_out;
   localparam int CORDW = 10;

   logic             clk_pix = 1'b0;
   logic             rst = 1'b0;
   logic             clr_underflow = 1'b0;
   logic [CORDW-1:0] sx, sy;
   logic             frame_start, underflow, vga_hsync, vga_vsync;
   logic [5:0]       vga_r, vga_g, vga_b;

   always #5 clk_pix = ~clk_pix;

   vga_stream_out_if fifo_if ();

   vga_stream_out #(
      .CORDW(CORDW),
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
      .H_POL(1'b0), .V_POL(1'b0)
   ) dut (
      .clk_pix(clk_pix),
      .rst(rst),
      .fifo(fifo_if),
      .clr_underflow(clr_underflow),
      .sx(sx),
      .sy(sy),
      .frame_start(frame_start),
      .underflow(underflow),
      .vga_hsync(vga_hsync),
      .vga_vsync(vga_vsync),
      .vga_r(vga_r),
      .vga_g(vga_g),
      .vga_b(vga_b)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0d: got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [17:0] rgb_of(input logic [15:0] p);
      return {p[15:11], p[15], p[10:5], p[4:0], p[4]};
   endfunction

   bit          de_a [0:511];
   bit          hs_a [0:511];
   bit          rd_a [0:511];
   logic [15:0] dout_a [0:511];

   initial begin
      int sx_m, sy_m, rd_cnt, last_fs;
      bit uf_m, emp, clr, vs_m2;
      logic [17:0] rgb_e;
      logic [15:0] dv;

      fifo_if.fifo_empty = 1'b0;
      fifo_if.fifo_dout  = 16'h0000;
      rst = 1'b0;
      repeat (2) @(posedge clk_pix);
      #1;
      rst     = 1'b1;
      uf_m    = 1'b0;
      rd_cnt  = 0;
      last_fs = -1;

      for (int t = 0; t <= 421; t++) begin
         cyc  = t;
         sx_m = t % 16;
         sy_m = (t / 16) % 8;
         de_a[t] = (sx_m < 8) && (sy_m < 4);
         hs_a[t] = (sx_m >= 10) && (sx_m < 13);

         // registered / stage-0 outputs against the model
         check("sx", sx, sx_m);
         check("sy", sy, sy_m);
         check("frame_start", frame_start, (sx_m == 0) && (sy_m == 0));
         check("hsync", vga_hsync, (t >= 2) ? !hs_a[t-2] : 1'b1);
         vs_m2 = (t >= 2) && ((((t - 2) / 16) % 8) == 5);
         check("vsync", vga_vsync, !vs_m2);
         rgb_e = (t >= 2 && rd_a[t-2]) ? rgb_of(dout_a[t-1]) : 18'd0;
         check("rgb", {vga_r, vga_g, vga_b}, rgb_e);
         check("underflow", underflow, uf_m);

         // hand-computed directed points
         case (t)
            11:  check("hsync_pre",  vga_hsync, 1'b1);
            12:  check("hsync_low0", vga_hsync, 1'b0);
            14:  check("hsync_low2", vga_hsync, 1'b0);
            15:  check("hsync_post", vga_hsync, 1'b1);
            258: check("rgb_red",   {vga_r, vga_g, vga_b}, {6'd63, 6'd0, 6'd0});
            259: check("rgb_green", {vga_r, vga_g, vga_b}, {6'd0, 6'd63, 6'd0});
            260: check("rgb_blue",  {vga_r, vga_g, vga_b}, {6'd0, 6'd0, 6'd63});
            261: check("rgb_0821",  {vga_r, vga_g, vga_b}, {6'd2, 6'd1, 6'd2});
            276: check("uf_set", underflow, 1'b1);
            277: check("rgb_underrun_black", {vga_r, vga_g, vga_b}, 18'd0);
            290: check("uf_held", underflow, 1'b1);
            291: check("uf_cleared", underflow, 1'b0);
            309: check("uf_set_wins", underflow, 1'b1);
            311: check("uf_clr_only", underflow, 1'b0);
            337: check("uf_blank_no_set", underflow, 1'b0);
            417: check("uf_set_pre_rst", underflow, 1'b1);
            default: ;
         endcase

         // drive inputs for this cycle
         emp = (t == 275) || (t == 308) || (t == 336) || (t == 416);
         clr = (t == 290) || (t == 308) || (t == 310);
         case (t)
            257:     dv = 16'hF800;
            258:     dv = 16'h07E0;
            259:     dv = 16'h001F;
            260:     dv = 16'h0821;
            default: dv = 16'(t * 40503);
         endcase
         dout_a[t] = dv;
         rd_a[t]   = de_a[t] && !emp;
         fifo_if.fifo_empty = emp;
         fifo_if.fifo_dout  = dv;
         clr_underflow      = clr;
         #1;
         check("fifo_rd_en", fifo_if.fifo_rd_en, rd_a[t]);
         if (t == 275) check("rd_en_empty", fifo_if.fifo_rd_en, 1'b0);
         if (t == 336) check("rd_en_blank", fifo_if.fifo_rd_en, 1'b0);

         if (fifo_if.fifo_rd_en) rd_cnt++;
         if (frame_start) begin
            if (last_fs >= 0) check("frame_period", t - last_fs, 128);
            last_fs = t;
         end
         if (t == 127 || t == 255) begin
            check("rd_per_frame", rd_cnt, 32);
            rd_cnt = 0;
         end
         if (t == 383) begin
            check("rd_per_frame_underrun", rd_cnt, 30);
            rd_cnt = 0;
         end

         if (de_a[t] && emp) uf_m = 1'b1;
         else if (clr)       uf_m = 1'b0;

         // one-cycle reset at sx=5, sy=2
         if (t == 421) rst = 1'b0;
         @(posedge clk_pix);
         #1;
      end

      cyc = 422;
      rst = 1'b1;
      fifo_if.fifo_empty = 1'b0;
      clr_underflow      = 1'b0;
      check("rst_sx", sx, 0);
      check("rst_sy", sy, 0);
      check("rst_frame_start", frame_start, 1'b1);
      check("rst_rgb", {vga_r, vga_g, vga_b}, 18'd0);
      check("rst_hsync", vga_hsync, 1'b1);
      check("rst_vsync", vga_vsync, 1'b1);
      check("rst_underflow", underflow, 1'b0);
      @(posedge clk_pix);
      #1;
      cyc = 423;
      check("post_rst_sx", sx, 1);
      check("post_rst_sy", sy, 0);
      check("post_rst_frame_start", frame_start, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
